// File: rtl/otbn_pq_ctrlspr_file.sv
// PQ loop/index control SPR file: holds M, J2, J, Idx0/1, Mode, X, Y and applies
// ictrlspr read/write/read-set accesses plus the shared-decode update strobes.
module otbn_pq_ctrlspr_file #(
  parameter int unsigned PQLEN    = 32,
  parameter int unsigned IdxWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [11:0]         spr_addr_i,
  input  logic                spr_rd_en_i,
  input  logic                spr_wr_en_i,
  input  logic                spr_rs_en_i,
  input  logic [PQLEN-1:0]    spr_wdata_i,
  output logic [PQLEN-1:0]    spr_rdata_o,
  output logic                spr_rvalid_o,
  output logic                spr_err_o,
  input  logic                sl_m_i,
  input  logic                sl_j2_i,
  input  logic                inc_j_i,
  input  logic                inc_idx_i,
  input  logic                set_idx_i,
  input  logic                inc_x_i,
  input  logic                inc_y_i,
  output logic [PQLEN-1:0]    m_o,
  output logic [PQLEN-1:0]    j2_o,
  output logic [PQLEN-1:0]    j_o,
  output logic [PQLEN-1:0]    mode_o,
  output logic [IdxWidth-1:0] idx0_o,
  output logic [IdxWidth-1:0] idx1_o,
  output logic [2:0]          x_o,
  output logic [2:0]          y_o,
  output logic                j_wrap_o
);

  typedef enum logic [11:0] {
    SprM    = 12'h000,
    SprJ2   = 12'h001,
    SprJ    = 12'h002,
    SprIdx0 = 12'h003,
    SprIdx1 = 12'h004,
    SprMode = 12'h005,
    SprX    = 12'h006,
    SprY    = 12'h007
  } pqctrlspr_e;

  logic [PQLEN-1:0]    m_q, m_d, j2_q, j2_d, j_q, j_d, mode_q, mode_d;
  logic [IdxWidth-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [2:0]          x_q, x_d, y_q, y_d;
  logic [PQLEN-1:0]    rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d, err_q, err_d, j_wrap_q, j_wrap_d;

  logic                addr_mapped;
  logic [PQLEN-1:0]    cur_val;
  logic                access, acc_err, upd;
  logic [PQLEN-1:0]    upd_val;
  logic                j_last;
  logic [IdxWidth-1:0] idx_step;

  // Keccak lane coordinate step; out-of-range values (5..7) fall back to 0.
  function automatic logic [2:0] coord_inc(input logic [2:0] c);
    return (c >= 3'd4) ? 3'd0 : c + 3'd1;
  endfunction

  always_comb begin
    addr_mapped = 1'b1;
    cur_val     = '0;
    unique case (spr_addr_i)
      SprM:    cur_val = m_q;
      SprJ2:   cur_val = j2_q;
      SprJ:    cur_val = j_q;
      SprIdx0: cur_val = PQLEN'(idx0_q);
      SprIdx1: cur_val = PQLEN'(idx1_q);
      SprMode: cur_val = mode_q;
      SprX:    cur_val = PQLEN'(x_q);
      SprY:    cur_val = PQLEN'(y_q);
      default: addr_mapped = 1'b0;
    endcase
  end

  assign access  = spr_rd_en_i | spr_wr_en_i | spr_rs_en_i;
  assign acc_err = access & (~addr_mapped | (spr_wr_en_i & spr_rs_en_i));
  assign upd     = (spr_wr_en_i | spr_rs_en_i) & ~acc_err;
  assign upd_val = spr_wr_en_i ? spr_wdata_i : (cur_val | spr_wdata_i);

  // Last iteration of the inner J loop; J2 == 0 disables the loop entirely.
  assign j_last   = (j2_q != '0) && (j_q == j2_q - PQLEN'(1));
  assign idx_step = j_last ? j2_q[IdxWidth-1:0] + IdxWidth'(1) : IdxWidth'(1);

  always_comb begin
    m_d      = sl_m_i ? (m_q << 1) : m_q;
    j2_d     = sl_j2_i ? (j2_q >> 1) : j2_q;
    j_d      = j_q;
    j_wrap_d = 1'b0;
    mode_d   = mode_q;
    idx0_d   = idx0_q;
    idx1_d   = idx1_q;
    x_d      = inc_x_i ? coord_inc(x_q) : x_q;
    y_d      = inc_y_i ? coord_inc(y_q) : y_q;

    if (inc_j_i) begin
      j_d      = ((j2_q == '0) || j_last) ? '0 : j_q + PQLEN'(1);
      j_wrap_d = j_last;
    end

    if (set_idx_i) begin
      idx0_d = '0;
      idx1_d = j2_q[IdxWidth-1:0];
    end else if (inc_idx_i) begin
      idx0_d = idx0_q + idx_step;
      idx1_d = idx1_q + idx_step;
    end

    // SPR access overrides any strobe on the same register.
    if (upd) begin
      unique case (spr_addr_i)
        SprM:    m_d = upd_val;
        SprJ2:   j2_d = upd_val;
        SprJ: begin
          j_d      = upd_val;
          j_wrap_d = 1'b0;
        end
        SprIdx0: idx0_d = upd_val[IdxWidth-1:0];
        SprIdx1: idx1_d = upd_val[IdxWidth-1:0];
        SprMode: mode_d = upd_val;
        SprX:    x_d = upd_val[2:0];
        SprY:    y_d = upd_val[2:0];
        default: ;
      endcase
    end

    rvalid_d = (spr_rd_en_i | spr_rs_en_i) & ~acc_err;
    rdata_d  = rvalid_d ? cur_val : '0;
    err_d    = acc_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q      <= PQLEN'(1);
      j2_q     <= '0;
      j_q      <= '0;
      mode_q   <= '0;
      idx0_q   <= '0;
      idx1_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      j_wrap_q <= 1'b0;
    end else begin
      m_q      <= m_d;
      j2_q     <= j2_d;
      j_q      <= j_d;
      mode_q   <= mode_d;
      idx0_q   <= idx0_d;
      idx1_q   <= idx1_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      j_wrap_q <= j_wrap_d;
    end
  end

  assign m_o          = m_q;
  assign j2_o         = j2_q;
  assign j_o          = j_q;
  assign mode_o       = mode_q;
  assign idx0_o       = idx0_q;
  assign idx1_o       = idx1_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign spr_rdata_o  = rdata_q;
  assign spr_rvalid_o = rvalid_q;
  assign spr_err_o    = err_q;
  assign j_wrap_o     = j_wrap_q;

endmodule

// File: tb/tb_otbn_pq_ctrlspr_file.sv
// Bench for otbn_pq_ctrlspr_file: directed scenarios plus random traffic against a reference model.
module tb_otbn_pq_ctrlspr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] spr_addr_i;
  logic        spr_rd_en_i, spr_wr_en_i, spr_rs_en_i;
  logic [31:0] spr_wdata_i;
  logic [31:0] spr_rdata_o;
  logic        spr_rvalid_o, spr_err_o;
  logic        sl_m_i, sl_j2_i, inc_j_i, inc_idx_i, set_idx_i, inc_x_i, inc_y_i;
  logic [31:0] m_o, j2_o, j_o, mode_o;
  logic [7:0]  idx0_o, idx1_o;
  logic [2:0]  x_o, y_o;
  logic        j_wrap_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  otbn_pq_ctrlspr_file #(.PQLEN(32), .IdxWidth(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .spr_addr_i(spr_addr_i), .spr_rd_en_i(spr_rd_en_i),
    .spr_wr_en_i(spr_wr_en_i), .spr_rs_en_i(spr_rs_en_i), .spr_wdata_i(spr_wdata_i),
    .spr_rdata_o(spr_rdata_o), .spr_rvalid_o(spr_rvalid_o), .spr_err_o(spr_err_o),
    .sl_m_i(sl_m_i), .sl_j2_i(sl_j2_i), .inc_j_i(inc_j_i), .inc_idx_i(inc_idx_i),
    .set_idx_i(set_idx_i), .inc_x_i(inc_x_i), .inc_y_i(inc_y_i), .m_o(m_o), .j2_o(j2_o),
    .j_o(j_o), .mode_o(mode_o), .idx0_o(idx0_o), .idx1_o(idx1_o), .x_o(x_o), .y_o(y_o),
    .j_wrap_o(j_wrap_o)
  );

  task automatic idle();
    rst_i = 1'b0; spr_addr_i = '0; spr_rd_en_i = 0; spr_wr_en_i = 0; spr_rs_en_i = 0;
    spr_wdata_i = '0; sl_m_i = 0; sl_j2_i = 0; inc_j_i = 0; inc_idx_i = 0; set_idx_i = 0;
    inc_x_i = 0; inc_y_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    idle();
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    idle();
    spr_addr_i = a; spr_wr_en_i = 1'b1; spr_wdata_i = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_o, j2_o, j_o, mode_o, idx0_o, idx1_o, x_o, y_o} !== {32'd1, 96'd0, 16'd0, 6'd0}) begin
      errors++; $display("FAIL reset_regs: got m=%0h j2=%0h j=%0h mode=%0h want m=1 rest 0",
                         m_o, j2_o, j_o, mode_o);
    end
    checks++;
    if ({spr_rvalid_o, spr_err_o, j_wrap_o, spr_rdata_o} !== 35'd0) begin
      errors++; $display("FAIL reset_flags: got rv=%b err=%b wrap=%b rdata=%0h want all 0",
                         spr_rvalid_o, spr_err_o, j_wrap_o, spr_rdata_o);
    end
    spr_addr_i = 12'h000; spr_rd_en_i = 1'b1;
    step();
    checks++;
    if (spr_rvalid_o !== 1'b1 || spr_rdata_o !== 32'd1 || spr_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_read_m: got rv=%b rdata=%0h err=%b want 1 1 0",
                         spr_rvalid_o, spr_rdata_o, spr_err_o);
    end
    spr_addr_i = 12'h001;
    step();
    checks++;
    if (spr_rvalid_o !== 1'b1 || spr_rdata_o !== 32'd0 || spr_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_read_j2: got rv=%b rdata=%0h err=%b want 1 0 0",
                         spr_rvalid_o, spr_rdata_o, spr_err_o);
    end
    idle();
    step();
    checks++;
    if (spr_rvalid_o !== 1'b0 || spr_rdata_o !== 32'd0) begin
      errors++; $display("FAIL rvalid_drop: got rv=%b rdata=%0h want 0 0", spr_rvalid_o, spr_rdata_o);
    end
  endtask

  task automatic test_j_wrap();
    do_reset();
    do_write(12'h001, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      inc_j_i = 1'b1;
      step();
      checks++;
      if (j_o !== 32'(i % 4) || j_wrap_o !== (i == 4)) begin
        errors++; $display("FAIL j_wrap_%0d: got j=%0d wrap=%b want j=%0d wrap=%b",
                           i, j_o, j_wrap_o, i % 4, i == 4);
      end
    end
    idle();
    step();
    checks++;
    if (j_wrap_o !== 1'b0) begin
      errors++; $display("FAIL j_wrap_pulse: got %b want 0", j_wrap_o);
    end
  endtask

  task automatic test_idx();
    int exp_idx[8] = '{1, 2, 3, 8, 9, 10, 11, 16};
    do_reset();
    do_write(12'h001, 32'd4);
    set_idx_i = 1'b1;
    step();
    checks++;
    if (idx0_o !== 8'd0 || idx1_o !== 8'd4) begin
      errors++; $display("FAIL set_idx: got %0d/%0d want 0/4", idx0_o, idx1_o);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      inc_idx_i = 1'b1; inc_j_i = 1'b1;
      step();
      checks++;
      if (idx0_o !== 8'(exp_idx[i]) || idx1_o !== 8'(exp_idx[i] + 4)) begin
        errors++; $display("FAIL inc_idx_%0d: got %0d/%0d want %0d/%0d",
                           i, idx0_o, idx1_o, exp_idx[i], exp_idx[i] + 4);
      end
    end
    idle();
  endtask

  task automatic test_read_set();
    do_reset();
    do_write(12'h005, 32'h0F0);
    spr_addr_i = 12'h005; spr_rs_en_i = 1'b1; spr_wdata_i = 32'h00F;
    step();
    checks++;
    if (spr_rvalid_o !== 1'b1 || spr_rdata_o !== 32'h0F0 || mode_o !== 32'h0FF) begin
      errors++; $display("FAIL read_set: got rv=%b rdata=%0h mode=%0h want 1 f0 ff",
                         spr_rvalid_o, spr_rdata_o, mode_o);
    end
    idle();
    spr_addr_i = 12'h005; spr_rd_en_i = 1'b1;
    step();
    checks++;
    if (spr_rdata_o !== 32'h0FF) begin
      errors++; $display("FAIL read_after_set: got %0h want ff", spr_rdata_o);
    end
    idle();
  endtask

  task automatic test_errors();
    do_reset();
    spr_addr_i = 12'h010; spr_rd_en_i = 1'b1;
    step();
    checks++;
    if (spr_err_o !== 1'b1 || spr_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL err_unmapped: got err=%b rv=%b want 1 0", spr_err_o, spr_rvalid_o);
    end
    idle();
    spr_addr_i = 12'h000; spr_wr_en_i = 1'b1; spr_rs_en_i = 1'b1; spr_wdata_i = 32'h55;
    step();
    checks++;
    if (spr_err_o !== 1'b1 || spr_rvalid_o !== 1'b0 || m_o !== 32'd1) begin
      errors++; $display("FAIL err_wr_rs: got err=%b rv=%b m=%0h want 1 0 1",
                         spr_err_o, spr_rvalid_o, m_o);
    end
    idle();
    step();
    checks++;
    if (spr_err_o !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got %b want 0", spr_err_o);
    end
  endtask

  task automatic test_coord_and_priority();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      inc_x_i = 1'b1;
      step();
      checks++;
      if (x_o !== 3'(i % 5)) begin
        errors++; $display("FAIL inc_x_%0d: got %0d want %0d", i, x_o, i % 5);
      end
    end
    idle();
    do_write(12'h007, 32'd6);
    inc_y_i = 1'b1;
    step();
    checks++;
    if (y_o !== 3'd0) begin
      errors++; $display("FAIL inc_y_oob: got %0d want 0", y_o);
    end
    idle();
    spr_addr_i = 12'h000; spr_wr_en_i = 1'b1; spr_wdata_i = 32'h80; sl_m_i = 1'b1;
    step();
    checks++;
    if (m_o !== 32'h80) begin
      errors++; $display("FAIL wr_over_sl_m: got %0h want 80", m_o);
    end
    // All strobes high under reset: reset must win.
    rst_i = 1'b1; spr_addr_i = 12'h002; spr_rd_en_i = 1'b1; spr_wdata_i = 32'hFF;
    spr_wr_en_i = 1'b1; sl_m_i = 1; sl_j2_i = 1; inc_j_i = 1; inc_idx_i = 1; set_idx_i = 1;
    inc_x_i = 1; inc_y_i = 1;
    step();
    idle();
    checks++;
    if ({m_o, j2_o, j_o, mode_o, idx0_o, idx1_o, x_o, y_o, spr_rvalid_o, spr_err_o, j_wrap_o}
        !== {32'd1, 96'd0, 16'd0, 6'd0, 3'd0}) begin
      errors++; $display("FAIL reset_wins: got m=%0h j=%0h idx0=%0d x=%0d rv=%b want reset values",
                         m_o, j_o, idx0_o, x_o, spr_rvalid_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] mm, mj2, mj, mmode, mi0, mi1, mx, my;
    logic [31:0] e_rdata, old, nv, stp;
    logic        e_rv, e_err, e_wrap, err;
    int          a;
    do_reset();
    mm = 1; mj2 = 0; mj = 0; mmode = 0; mi0 = 0; mi1 = 0; mx = 0; my = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_i       = ($urandom_range(0, 63) == 0);
      a           = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 4095) : $urandom_range(0, 7);
      spr_addr_i  = 12'(a);
      spr_rd_en_i = ($urandom_range(0, 3) == 0);
      spr_wr_en_i = ($urandom_range(0, 3) == 0);
      spr_rs_en_i = ($urandom_range(0, 7) == 0);
      spr_wdata_i = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom();
      sl_m_i = ($urandom_range(0, 7) == 0); sl_j2_i = ($urandom_range(0, 7) == 0);
      inc_j_i = $urandom_range(0, 1); inc_idx_i = $urandom_range(0, 1);
      set_idx_i = ($urandom_range(0, 5) == 0);
      inc_x_i = $urandom_range(0, 1); inc_y_i = $urandom_range(0, 1);

      case (a)
        0: old = mm;   1: old = mj2; 2: old = mj; 3: old = mi0;
        4: old = mi1;  5: old = mmode; 6: old = mx; 7: old = my;
        default: old = 0;
      endcase
      err = (spr_rd_en_i || spr_wr_en_i || spr_rs_en_i) &&
            (a > 7 || (spr_wr_en_i && spr_rs_en_i));
      e_err   = err;
      e_rv    = (spr_rd_en_i || spr_rs_en_i) && !err;
      e_rdata = e_rv ? old : 0;
      e_wrap  = 0;
      if (rst_i) begin
        mm = 1; mj2 = 0; mj = 0; mmode = 0; mi0 = 0; mi1 = 0; mx = 0; my = 0;
        e_rdata = 0; e_rv = 0; e_err = 0;
      end else begin
        // Loop semantics from pre-update values.
        stp = (mj2 != 0 && mj == mj2 - 1) ? mj2 + 1 : 1;
        if (set_idx_i) begin
          mi0 = 0; mi1 = mj2 % 256;
        end else if (inc_idx_i) begin
          mi0 = (mi0 + stp) % 256; mi1 = (mi1 + stp) % 256;
        end
        if (inc_j_i) begin
          if (mj2 == 0) mj = 0;
          else if (mj == mj2 - 1) begin mj = 0; e_wrap = 1; end
          else mj = mj + 1;
        end
        if (sl_m_i) mm = mm << 1;
        if (sl_j2_i) mj2 = mj2 >> 1;
        if (inc_x_i) mx = (mx >= 4) ? 0 : mx + 1;
        if (inc_y_i) my = (my >= 4) ? 0 : my + 1;
        if (!err && (spr_wr_en_i || spr_rs_en_i)) begin
          nv = spr_wr_en_i ? spr_wdata_i : (old | spr_wdata_i);
          case (a)
            0: mm = nv;  1: mj2 = nv;
            2: begin mj = nv; e_wrap = 0; end
            3: mi0 = nv % 256;  4: mi1 = nv % 256;  5: mmode = nv;
            6: mx = nv % 8;     7: my = nv % 8;
            default: ;
          endcase
        end
      end
      step();
      checks++;
      if (spr_rvalid_o !== e_rv || spr_rdata_o !== e_rdata || spr_err_o !== e_err) begin
        errors++; $display("FAIL rnd_access_%0d: got rv=%b rdata=%0h err=%b want rv=%b rdata=%0h err=%b",
                           n, spr_rvalid_o, spr_rdata_o, spr_err_o, e_rv, e_rdata, e_err);
      end
      checks++;
      if (m_o !== mm || j2_o !== mj2 || j_o !== mj || mode_o !== mmode || j_wrap_o !== e_wrap) begin
        errors++; $display("FAIL rnd_loop_%0d: got m=%0h j2=%0h j=%0h mode=%0h wrap=%b want %0h %0h %0h %0h %b",
                           n, m_o, j2_o, j_o, mode_o, j_wrap_o, mm, mj2, mj, mmode, e_wrap);
      end
      checks++;
      if (idx0_o !== mi0[7:0] || idx1_o !== mi1[7:0] || x_o !== mx[2:0] || y_o !== my[2:0]) begin
        errors++; $display("FAIL rnd_idx_%0d: got i0=%0d i1=%0d x=%0d y=%0d want %0d %0d %0d %0d",
                           n, idx0_o, idx1_o, x_o, y_o, mi0, mi1, mx, my);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    step();
    test_reset();
    test_j_wrap();
    test_idx();
    test_read_set();
    test_errors();
    test_coord_and_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
